// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single synchronous SRAM: a CPU bridge (port 0) and an accelerator (port 1).
// Round-robin when open; a locking owner keeps the SRAM for up to LOCK_MAX grants while the other port waits.
module sram_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0,
  input  logic              lock0,
  input  logic [AW-1:0]     addr0,
  input  logic [DW/8-1:0]   wen0,
  input  logic [DW-1:0]     wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DW-1:0]     rdata0,

  input  logic              req1,
  input  logic              lock1,
  input  logic [AW-1:0]     addr1,
  input  logic [DW/8-1:0]   wen1,
  input  logic [DW-1:0]     wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DW-1:0]     rdata1,

  output logic [AW-1:0]     SRAMADDR,
  output logic [DW/8-1:0]   SRAMWEN,
  output logic [DW-1:0]     SRAMWDATA,
  output logic              SRAMCS,
  input  logic [DW-1:0]     SRAMRDATA
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_MAX);

  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_mode_e;

  logic          last;
  logic          owner_lock;
  logic [CW-1:0] lock_cnt;
  logic          rvalid0_q;
  logic          rvalid1_q;

  arb_mode_e     arb_mode;
  logic          owner_req;
  logic          owner_lk;
  logic          other_req;
  logic          gnt_any;
  logic          gnt_idx;
  logic          gnt_lock;
  logic          last_nxt;
  logic          owner_lock_nxt;
  logic [CW-1:0] lock_cnt_nxt;

  // Arbitration state; a read granted while reset is high must never surface as rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last       <= 1'b1;
      owner_lock <= 1'b0;
      lock_cnt   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      last       <= last_nxt;
      owner_lock <= owner_lock_nxt;
      lock_cnt   <= lock_cnt_nxt;
      rvalid0_q  <= gnt0 && (wen0 == '0);
      rvalid1_q  <= gnt1 && (wen1 == '0);
    end
  end

  // The lock only holds while its owner keeps both req and lock high, so a drop reopens arbitration at once.
  always_comb begin
    owner_req = last ? req1  : req0;
    owner_lk  = last ? lock1 : lock0;
    other_req = last ? req0  : req1;
    arb_mode  = (owner_lock && owner_req && owner_lk) ? ARB_LOCKED : ARB_OPEN;

    gnt_any = 1'b0;
    gnt_idx = last;
    if (arb_mode == ARB_LOCKED) begin
      gnt_any = 1'b1;
      gnt_idx = (lock_cnt == LOCK_LIMIT && other_req) ? ~last : last;
    end else if (req0 && req1) begin
      gnt_any = 1'b1;
      gnt_idx = ~last;
    end else if (req0) begin
      gnt_any = 1'b1;
      gnt_idx = 1'b0;
    end else if (req1) begin
      gnt_any = 1'b1;
      gnt_idx = 1'b1;
    end

    gnt_lock       = gnt_idx ? lock1 : lock0;
    last_nxt       = gnt_any ? gnt_idx : last;
    owner_lock_nxt = gnt_any && gnt_lock;

    // A locked run continues only when the same port was granted with lock last cycle.
    lock_cnt_nxt = '0;
    if (gnt_any && gnt_lock) begin
      if (owner_lock && (gnt_idx == last))
        lock_cnt_nxt = (lock_cnt == LOCK_LIMIT) ? lock_cnt : lock_cnt + CW'(1);
      else
        lock_cnt_nxt = CW'(1);
    end
  end

  always_comb begin
    gnt0      = gnt_any && !gnt_idx;
    gnt1      = gnt_any && gnt_idx;
    SRAMCS    = gnt_any;
    SRAMADDR  = '0;
    SRAMWEN   = '0;
    SRAMWDATA = '0;
    if (gnt0) begin
      SRAMADDR  = addr0;
      SRAMWEN   = wen0;
      SRAMWDATA = wdata0;
    end else if (gnt1) begin
      SRAMADDR  = addr1;
      SRAMWEN   = wen1;
      SRAMWDATA = wdata1;
    end
    rvalid0 = rvalid0_q;
    rvalid1 = rvalid1_q;
    rdata0  = rvalid0_q ? SRAMRDATA : '0;
    rdata1  = rvalid1_q ? SRAMRDATA : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of arbitration and SRAM contents.
module tb_sram_port_arbiter;

  localparam int AW       = 16;
  localparam int DW       = 32;
  localparam int BW       = DW / 8;
  localparam int LOCK_MAX = 8;

  logic          clk;
  logic          reset;
  logic          req0, lock0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [BW-1:0] wen0;
  logic [DW-1:0] wdata0, rdata0;
  logic          req1, lock1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [BW-1:0] wen1;
  logic [DW-1:0] wdata1, rdata1;
  logic [AW-1:0] SRAMADDR;
  logic [BW-1:0] SRAMWEN;
  logic [DW-1:0] SRAMWDATA;
  logic          SRAMCS;
  logic [DW-1:0] SRAMRDATA;

  int total;
  int bad;

  sram_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .addr0(addr0), .wen0(wen0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .addr1(addr1), .wen1(wen1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .SRAMADDR(SRAMADDR), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA),
    .SRAMCS(SRAMCS), .SRAMRDATA(SRAMRDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memInit(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic l0, input logic [AW-1:0] a0,
                               input logic [BW-1:0] w0, input logic [DW-1:0] d0,
                               input logic r1, input logic l1, input logic [AW-1:0] a1,
                               input logic [BW-1:0] w1, input logic [DW-1:0] d1);
    req0 = r0; lock0 = l0; addr0 = a0; wen0 = w0; wdata0 = d0;
    req1 = r1; lock1 = l1; addr1 = a1; wen1 = w1; wdata1 = d1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Synchronous SRAM stand-in: the request is captured mid-cycle and performed at the following edge.
  initial begin : sram_model
    logic [DW-1:0] mem [0:255];
    logic          cs_s;
    logic [7:0]    addr_s;
    logic [BW-1:0] wen_s;
    logic [DW-1:0] wdata_s;
    for (int i = 0; i < 256; i++) mem[i] = memInit(i);
    mem[16] = 32'hDEAD_BEEF;
    SRAMRDATA <= '0;
    forever begin
      @(negedge clk);
      cs_s = SRAMCS; addr_s = SRAMADDR[7:0]; wen_s = SRAMWEN; wdata_s = SRAMWDATA;
      @(posedge clk);
      if (cs_s && wen_s == '0) begin
        SRAMRDATA <= mem[addr_s];
      end else begin
        if (cs_s)
          for (int b = 0; b < BW; b++)
            if (wen_s[b]) mem[addr_s][8*b +: 8] = wdata_s[8*b +: 8];
        SRAMRDATA <= $urandom;
      end
    end
  end

  // Reference model: who should own the SRAM this cycle, and what each port's pending read returns.
  initial begin : compare
    logic [DW-1:0] mmem [0:255];
    int            m_last, m_cnt, g, owner, other;
    bit            m_lock;
    bit            m_rv [2];
    logic [DW-1:0] m_rd [2];
    bit            r [2];
    bit            l [2];
    logic [AW-1:0] a [2];
    logic [BW-1:0] w [2];
    logic [DW-1:0] d [2];
    for (int i = 0; i < 256; i++) mmem[i] = memInit(i);
    mmem[16] = 32'hDEAD_BEEF;
    m_last = 1; m_cnt = 0; m_lock = 1'b0;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
    forever begin
      @(negedge clk);
      r[0] = req0; l[0] = lock0; a[0] = addr0; w[0] = wen0; d[0] = wdata0;
      r[1] = req1; l[1] = lock1; a[1] = addr1; w[1] = wen1; d[1] = wdata1;
      if (reset) begin
        m_last = 1; m_cnt = 0; m_lock = 1'b0; m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      end
      owner = m_last;
      other = 1 - m_last;
      if (m_lock && r[owner] && l[owner])
        g = (m_cnt >= LOCK_MAX && r[other]) ? other : owner;
      else if (r[0] && r[1]) g = 1 - m_last;
      else if (r[0])         g = 0;
      else if (r[1])         g = 1;
      else                   g = -1;

      checkOutput("model_gnt0", 32'(gnt0), 32'(g == 0));
      checkOutput("model_gnt1", 32'(gnt1), 32'(g == 1));
      checkOutput("model_cs", 32'(SRAMCS), 32'(g >= 0));
      checkOutput("model_addr", 32'(SRAMADDR), (g >= 0) ? 32'(a[g]) : 32'h0);
      checkOutput("model_wen", 32'(SRAMWEN), (g >= 0) ? 32'(w[g]) : 32'h0);
      checkOutput("model_wdata", 32'(SRAMWDATA), (g >= 0) ? d[g] : 32'h0);
      checkOutput("model_rvalid0", 32'(rvalid0), 32'(m_rv[0]));
      checkOutput("model_rvalid1", 32'(rvalid1), 32'(m_rv[1]));
      checkOutput("model_rdata0", rdata0, m_rv[0] ? m_rd[0] : 32'h0);
      checkOutput("model_rdata1", rdata1, m_rv[1] ? m_rd[1] : 32'h0);

      if (g >= 0 && w[g] != '0)
        for (int b = 0; b < BW; b++)
          if (w[g][b]) mmem[a[g][7:0]][8*b +: 8] = d[g][8*b +: 8];
      if (!reset) begin
        for (int i = 0; i < 2; i++) begin
          m_rv[i] = (g == i) && (w[i] == '0);
          if (m_rv[i]) m_rd[i] = mmem[a[i][7:0]];
        end
        if (g >= 0) begin
          if (l[g])
            m_cnt = (m_lock && m_last == g) ? ((m_cnt < LOCK_MAX) ? m_cnt + 1 : LOCK_MAX) : 1;
          else
            m_cnt = 0;
          m_lock = l[g];
          m_last = g;
        end else begin
          m_cnt = 0;
          m_lock = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit g0s, g1s;
    total = 0;
    bad = 0;
    reset = 1'b1;
    idle();
    repeat (3) nextCycle();

    // Release with both ports reading: round-robin starting at port 0.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0001, '0, '0, 1'b1, 1'b0, 16'h0002, '0, '0);
    @(negedge clk);
    checkOutput("rr_c0_gnt0", 32'(gnt0), 32'd1);
    checkOutput("rr_c0_gnt1", 32'(gnt1), 32'd0);
    nextCycle(); @(negedge clk);
    checkOutput("rr_c1_gnt1", 32'(gnt1), 32'd1);
    checkOutput("rr_c1_rvalid0", 32'(rvalid0), 32'd1);
    nextCycle(); @(negedge clk);
    checkOutput("rr_c2_gnt0", 32'(gnt0), 32'd1);
    checkOutput("rr_c2_rvalid1", 32'(rvalid1), 32'd1);
    nextCycle(); idle(); @(negedge clk);
    checkOutput("rr_c3_rvalid0", 32'(rvalid0), 32'd1);
    checkOutput("rr_c3_rvalid1", 32'(rvalid1), 32'd0);

    // Port 0 read of 0x0010.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'h0010, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("rd_cs", 32'(SRAMCS), 32'd1);
    checkOutput("rd_addr", 32'(SRAMADDR), 32'h0010);
    checkOutput("rd_wen", 32'(SRAMWEN), 32'h0);
    nextCycle(); idle(); @(negedge clk);
    checkOutput("rd_rvalid0", 32'(rvalid0), 32'd1);
    checkOutput("rd_rdata0", rdata0, 32'hDEAD_BEEF);

    // Port 1 partial write.
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 16'h0020, 4'b0011, 32'h1234_5678);
    @(negedge clk);
    checkOutput("wr_gnt1", 32'(gnt1), 32'd1);
    checkOutput("wr_wen", 32'(SRAMWEN), 32'h3);
    checkOutput("wr_wdata", SRAMWDATA, 32'h1234_5678);
    nextCycle(); idle(); @(negedge clk);
    checkOutput("wr_no_rvalid1", 32'(rvalid1), 32'd0);

    // Port 0 locks against a waiting port 1: eight grants, forced yield, then port 0 again.
    nextCycle();
    applyStimulus(1'b1, 1'b1, 16'h0004, '0, '0, 1'b1, 1'b0, 16'h0005, '0, '0);
    for (int k = 0; k < LOCK_MAX; k++) begin
      @(negedge clk);
      checkOutput($sformatf("lock_run%0d_gnt0", k), 32'(gnt0), 32'd1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("lock_yield_gnt1", 32'(gnt1), 32'd1);
    checkOutput("lock_yield_gnt0", 32'(gnt0), 32'd0);
    nextCycle(); @(negedge clk);
    checkOutput("lock_back_gnt0", 32'(gnt0), 32'd1);
    nextCycle(); idle();

    // Port 1 owns the lock, then drops it while port 0 waits.
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 16'h0006, '0, '0);
    @(negedge clk);
    checkOutput("drop_own_gnt1", 32'(gnt1), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'h0007, '0, '0, 1'b1, 1'b1, 16'h0006, '0, '0);
    @(negedge clk);
    checkOutput("drop_held_gnt1", 32'(gnt1), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'h0007, '0, '0, 1'b1, 1'b0, 16'h0006, '0, '0);
    @(negedge clk);
    checkOutput("drop_gnt0", 32'(gnt0), 32'd1);
    checkOutput("drop_gnt1", 32'(gnt1), 32'd0);
    nextCycle(); idle();

    // Reset right after a read grant.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'h0010, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("rst_pre_gnt0", 32'(gnt0), 32'd1);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0010, '0, '0, 1'b1, 1'b0, 16'h0011, '0, '0);
    @(negedge clk);
    checkOutput("rst_rvalid0", 32'(rvalid0), 32'd0);
    checkOutput("rst_rdata0", rdata0, 32'h0);
    checkOutput("rst_open_gnt0", 32'(gnt0), 32'd1);
    nextCycle(); @(negedge clk);
    checkOutput("rst_hold_rvalid0", 32'(rvalid0), 32'd0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_rel_gnt0", 32'(gnt0), 32'd1);
    checkOutput("rst_rel_gnt1", 32'(gnt1), 32'd0);
    nextCycle(); @(negedge clk);
    checkOutput("rst_rel_rvalid0", 32'(rvalid0), 32'd1);
    checkOutput("rst_rel_next_gnt1", 32'(gnt1), 32'd1);
    nextCycle(); idle();

    // Randomized traffic; each port holds its request until granted, lock toggles freely.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      g0s = gnt0;
      g1s = gnt1;
      nextCycle();
      if (c == 300) reset = 1'b1;
      if (c == 303) reset = 1'b0;
      if (!req0 || g0s) begin
        req0   = ($urandom_range(0, 3) != 0);
        addr0  = AW'($urandom_range(0, 31));
        wen0   = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom_range(1, 15));
        wdata0 = $urandom;
      end
      if (!req1 || g1s) begin
        req1   = ($urandom_range(0, 3) != 0);
        addr1  = AW'($urandom_range(0, 31));
        wen1   = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom_range(1, 15));
        wdata1 = $urandom;
      end
      lock0 = ($urandom_range(0, 7) != 0);
      lock1 = ($urandom_range(0, 7) != 0);
    end
    idle();
    repeat (3) nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 16, meaning SRAM word-address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning SRAM data width (DW/8 byte lanes).
REQ-003 The block SHALL have parameter LOCK_MAX, default 8, meaning the maximum number of consecutive locked grants before a forced yield.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset: port clk (in, 1) is the single clock; port reset (in, 1) is the asynchronous, active-high reset.
REQ-005 Requester ports, n = 0 (CPU AHB-to-SRAM bridge), 1 (accelerator), each SHALL be:
- reqN in 1: access request.
- lockN in 1: hold ownership for back-to-back accesses.
- addrN in AW: word address.
- wenN in DW/8: byte write enables; all-zero means read.
- wdataN in DW: write data.
- gntN out 1: access issued this cycle.
- rvalidN out 1: read data valid.
- rdataN out DW: read data.
REQ-006 SRAM ports SHALL be:
- SRAMADDR out AW.
- SRAMWEN out DW/8.
- SRAMWDATA out DW.
- SRAMCS out 1.
- SRAMRDATA in DW: synchronous SRAM, data one cycle after CS.

Function
REQ-007 gnt0/gnt1 SHALL be combinational from req, lock and internal state; at most one asserted per cycle.
REQ-008 A request SHALL be accepted in the cycle its gnt is high; the requester holds req/addr/wen/wdata stable until gnt.
REQ-009 State registers SHALL be:
- last (1 bit): last granted requester.
- owner_lock (1 bit): lock active.
- lock_cnt (width ceil(log2(LOCK_MAX+1))).
REQ-010 Arbitration state LOCKED (owner_lock=1), with last requester still asserting req and lock, SHALL work as follows:
- Grant last while lock_cnt < LOCK_MAX.
- At lock_cnt == LOCK_MAX, grant the other requester if it is requesting; otherwise keep granting last.
REQ-011 Arbitration state OPEN (not LOCKED) SHALL work as follows:
- Single requester wins.
- Both requesting: grant !last (round-robin).
- None: no grant.
REQ-012 On every grant, last SHALL update to the granted index.
REQ-013 owner_lock SHALL be set to the granted requester's lock value. With no grant, owner_lock SHALL be cleared.
REQ-014 lock_cnt SHALL behave as follows:
- Increment (saturating at LOCK_MAX) on a locked grant to the same owner as the previous cycle.
- Load 1 on a locked grant to a new owner.
- Clear to 0 on unlocked grant or idle.
REQ-015 A locked owner dropping req or lock SHALL return arbitration to OPEN in the same cycle.
REQ-016 SRAMCS SHALL equal gnt0|gnt1. SRAMADDR, SRAMWEN and SRAMWDATA SHALL mux the granted requester, and SHALL be all-zero when no grant.
REQ-017 rvalidN SHALL be a register set to 1 the cycle after gntN with wenN == 0, else 0; read latency is exactly 1 cycle from gnt.
REQ-018 rdataN SHALL equal SRAMRDATA when rvalidN=1, else 0.
REQ-019 Writes SHALL produce no rvalid.
REQ-020 Back-to-back grants (one per cycle, any mix) SHALL be supported with no bubble.
REQ-021 gnt SHALL be suppressed when reqN=0 regardless of lockN.

Reset
REQ-022 While reset=1, the block SHALL hold:
- last=1 (requester 0 wins first tie).
- owner_lock=0, lock_cnt=0.
- rvalid0=rvalid1=0, rdata0=rdata1=0.
REQ-023 Reset asserted mid-operation SHALL immediately clear rvalid and lock state; a read granted in the reset cycle SHALL NOT produce rvalid.
REQ-024 All outputs SHALL be deterministic during reset: gnt/SRAM outputs follow REQ-011/REQ-016 with OPEN state.

Verification
REQ-025 The bench SHALL cover reset release with req0=req1=1, reads:
- gnt0 in cycle 0, gnt1 in cycle 1, gnt0 in cycle 2.
- rvalid0 in cycles 1 and 3, rvalid1 in cycle 2.
REQ-026 The bench SHALL cover req0 read of addr 0x0010 with SRAMRDATA=0xDEADBEEF next cycle:
- SRAMCS=1, SRAMADDR=0x0010, SRAMWEN=0 in cycle t.
- rvalid0=1, rdata0=0xDEADBEEF in cycle t+1.
REQ-027 The bench SHALL cover req1 write, wen1=4'b0011, wdata1=0x12345678 -> SRAMWEN=0011, SRAMWDATA=0x12345678, no rvalid1 the next cycle.
REQ-028 The bench SHALL cover req0+lock0 held, req1 held, LOCK_MAX=8:
- gnt0 for 8 consecutive cycles, then gnt1.
- Then gnt0 again (lock_cnt reloads 1).
REQ-029 The bench SHALL cover locked owner 1 dropping lock1 while req0=1 -> gnt0 that same cycle.
REQ-030 The bench SHALL cover reset asserted the cycle after a read grant -> rvalid forced 0; after release, both requesting -> gnt0 first.
